// File: rtl/tm1638_refresh_ctrl_if.sv
// ---------------------------------------------------------------------------
// tm1638_refresh_ctrl_if
// Request/status bundle between the display-data producer and the TM1638
// refresh controller.
//   start     one-cycle request to send a frame           (master -> slave)
//   seg_data  8 segment bytes, digit i = [8i+7:8i]         (master -> slave)
//   led       LED i on when led[i] = 1                     (master -> slave)
//   bright    brightness 0..7                              (master -> slave)
//   disp_on   1 = display enabled                          (master -> slave)
//   busy      frame in progress                            (slave -> master)
//   done      one-cycle pulse at frame end                 (slave -> master)
// ---------------------------------------------------------------------------
interface tm1638_refresh_ctrl_if;
    logic        start;
    logic [63:0] seg_data;
    logic [7:0]  led;
    logic [2:0]  bright;
    logic        disp_on;
    logic        busy;
    logic        done;

    modport master (
        output start, seg_data, led, bright, disp_on,
        input  busy, done
    );

    modport slave (
        input  start, seg_data, led, bright, disp_on,
        output busy, done
    );
endinterface

// File: rtl/tm1638_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// tm1638_refresh_ctrl
// Sends one complete TM1638 refresh frame over the stb/clk/dio pins:
// data command 0x40, address 0xC0 followed by 16 display bytes, and the
// display control byte. Inputs are snapshotted when a frame is accepted.
//
// Parameters
//   CLK_DIV         clk_50M cycles per tm_clk half-period
//   REFRESH_CYCLES  auto-refresh period (only with TM1638_AUTO_REFRESH_EN)
// Ports
//   clk_50M   system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       request/status interface (slave modport)
//   tm_stb    TM1638 STB, active low
//   tm_clk    TM1638 CLK, idle high
//   tm_dio    TM1638 DIO, write-only, idle high
// Configuration macro
//   TM1638_AUTO_REFRESH_EN  adds a free-running timer whose terminal count
//                           acts as an extra start request.
// ---------------------------------------------------------------------------
module tm1638_refresh_ctrl #(
    parameter int CLK_DIV        = 25,
    parameter int REFRESH_CYCLES = 2500000
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    tm1638_refresh_ctrl_if.slave        bus,
    output logic                        tm_stb,
    output logic                        tm_clk,
    output logic                        tm_dio
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, CMD_DATA, GAP1, ADDR_DATA, GAP2, CMD_DISP
    } state_t;

    // Position inside a transaction; in the gaps PH_SETUP/PH_HIGH mark the
    // first and second CLK_DIV half of the 2*CLK_DIV idle time.
    typedef enum logic [1:0] {
        PH_SETUP, PH_LOW, PH_HIGH, PH_TAIL
    } phase_t;

    state_t           state;
    phase_t           phase;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [4:0]       byte_cnt;
    logic [63:0]      seg_sh;
    logic [7:0]       led_sh;
    logic [2:0]       bright_sh;
    logic             disp_on_sh;
    logic             pending;
    logic             busy_r;
    logic             done_r;

    logic             req;
    logic             div_end;
    logic             last_byte;
    logic [2:0]       bit_nxt;
    logic [7:0]       cur_byte;
    logic [7:0]       nxt_byte;

    assign bus.busy = busy_r;
    assign bus.done = done_r;

`ifdef TM1638_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_cnt;
    logic          auto_tick;

    // Free-running period timer; its terminal count is an internal start.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign auto_tick = (refresh_cnt == REFRESH_LAST);
    assign req       = bus.start | auto_tick;
`else
    assign req = bus.start;
`endif

    assign div_end   = (div_cnt == DIV_LAST);
    assign last_byte = (state != ADDR_DATA) || (byte_cnt == 5'd16);
    assign bit_nxt   = bit_cnt + 3'd1;

    // Byte at position idx of the current transaction. In ADDR_DATA index 0
    // is the address command and index k>0 is display address k-1: even
    // addresses carry a digit's segments, odd ones the matching LED.
    function automatic logic [7:0] frame_byte(
        input state_t      st,
        input logic [4:0]  idx,
        input logic [63:0] seg,
        input logic [7:0]  leds,
        input logic [2:0]  br,
        input logic        on
    );
        logic [3:0] addr;
        logic [7:0] b;
        addr = 4'(idx - 5'd1);
        b    = 8'hFF;
        case (st)
            CMD_DATA:  b = 8'h40;
            ADDR_DATA: begin
                if (idx == 5'd0)
                    b = 8'hC0;
                else if (!addr[0])
                    b = seg[{addr[3:1], 3'b000} +: 8];
                else
                    b = {7'b0, leds[addr[3:1]]};
            end
            CMD_DISP:  b = on ? {5'b10001, br} : 8'h80;
            default:   b = 8'hFF;
        endcase
        return b;
    endfunction

    // Current byte and the one that follows it, from the snapshot registers.
    always_comb begin
        cur_byte = frame_byte(state, byte_cnt, seg_sh, led_sh, bright_sh, disp_on_sh);
        nxt_byte = frame_byte(state, byte_cnt + 5'd1, seg_sh, led_sh, bright_sh, disp_on_sh);
    end

    // Frame sequencer. Every timed step lasts CLK_DIV cycles, counted by
    // div_cnt; all pin values are registered so they change on clock edges.
    // A request seen outside IDLE is remembered in pending and starts the
    // next frame on the IDLE cycle that follows done.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= PH_SETUP;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            seg_sh     <= '0;
            led_sh     <= '0;
            bright_sh  <= '0;
            disp_on_sh <= 1'b0;
            pending    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            tm_dio     <= 1'b1;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE && req) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req || pending) begin
                        seg_sh     <= bus.seg_data;
                        led_sh     <= bus.led;
                        bright_sh  <= bus.bright;
                        disp_on_sh <= bus.disp_on;
                        pending    <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= CMD_DATA;
                        phase      <= PH_SETUP;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        byte_cnt   <= '0;
                        tm_stb     <= 1'b0;
                    end
                end

                GAP1, GAP2: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (phase == PH_SETUP) begin
                            phase <= PH_HIGH;
                        end else begin
                            phase  <= PH_SETUP;
                            state  <= (state == GAP1) ? ADDR_DATA : CMD_DISP;
                            tm_stb <= 1'b0;
                        end
                    end
                end

                CMD_DATA, ADDR_DATA, CMD_DISP: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        case (phase)
                            PH_SETUP: begin
                                phase  <= PH_LOW;
                                tm_clk <= 1'b0;
                                tm_dio <= cur_byte[bit_cnt];
                            end
                            PH_LOW: begin
                                phase  <= PH_HIGH;
                                tm_clk <= 1'b1;
                            end
                            PH_HIGH: begin
                                if (bit_cnt != 3'd7) begin
                                    bit_cnt <= bit_nxt;
                                    phase   <= PH_LOW;
                                    tm_clk  <= 1'b0;
                                    tm_dio  <= cur_byte[bit_nxt];
                                end else if (!last_byte) begin
                                    bit_cnt  <= 3'd0;
                                    byte_cnt <= byte_cnt + 5'd1;
                                    phase    <= PH_LOW;
                                    tm_clk   <= 1'b0;
                                    tm_dio   <= nxt_byte[0];
                                end else begin
                                    bit_cnt <= 3'd0;
                                    phase   <= PH_TAIL;
                                    tm_dio  <= 1'b1;
                                end
                            end
                            PH_TAIL: begin
                                tm_stb   <= 1'b1;
                                byte_cnt <= 5'd0;
                                phase    <= PH_SETUP;
                                if (state == CMD_DATA) begin
                                    state <= GAP1;
                                end else if (state == ADDR_DATA) begin
                                    state <= GAP2;
                                end else begin
                                    state  <= IDLE;
                                    done_r <= 1'b1;
                                    busy_r <= pending | req;
                                end
                            end
                            default: phase <= PH_SETUP;
                        endcase
                    end
                end

                default: begin
                    state  <= IDLE;
                    phase  <= PH_SETUP;
                    tm_stb <= 1'b1;
                    tm_clk <= 1'b1;
                    tm_dio <= 1'b1;
                end
            endcase
        end
    end

endmodule
